// File: rtl/pipeline_controller_if.sv
// Data-memory request/acknowledge handshake between the pipeline
// controller (master) and the data memory (slave).
interface pipeline_controller_if;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/pipeline_controller.sv
// Pipeline sequencing and hazard controller: memory-stage stalls with
// timeout, load-use bubble insertion, taken-branch squash, stall counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | pipeline flowing; memory ops, branches and hazards detected
// MEM_WAIT | data-memory request outstanding, pipeline held until ack
// ERROR    | memory timed out; pipeline held until reset
module pipeline_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_controller_if.master dmem,
    input  logic                  ext_halt,
    input  logic                  mem_memwrite,
    input  logic                  mem_memtoreg,
    input  logic                  ex_memtoreg,
    input  logic [4:0]            ex_write_addr,
    input  logic                  ex_branch_taken,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    output logic                  halt_if,
    output logic                  halt_id,
    output logic                  halt_ex,
    output logic                  halt_mem,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic                  busy,
    output logic                  mem_error,
    output logic [31:0]           stall_cycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic        req_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] stall_q;
    logic        mem_op;
    logic        load_use;
    logic        timeout_hit;

    assign mem_op      = mem_memwrite | mem_memtoreg;
    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    // Register 31 is the zero register, so a load targeting it never creates a dependency.
    assign load_use = ex_memtoreg && (ex_write_addr != 5'd31) &&
                      ((id_uses_rs1 && (id_rs1 == ex_write_addr)) ||
                       (id_uses_rs2 && (id_rs2 == ex_write_addr)));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mem_op && !ext_halt) state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (dmem.dmem_ack)    state_d = IDLE;
                else if (timeout_hit) state_d = ERROR;
            end
            ERROR:    state_d = ERROR;
            default:  state_d = IDLE;
        endcase
    end

    // Halt/flush outputs; reset holds every stage so nothing advances while rst is low.
    always_comb begin
        halt_if  = 1'b0;
        halt_id  = 1'b0;
        halt_ex  = 1'b0;
        halt_mem = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (!rst) begin
            {halt_if, halt_id, halt_ex, halt_mem} = 4'hf;
        end else begin
            case (state_q)
                MEM_WAIT: if (!dmem.dmem_ack || ext_halt) {halt_if, halt_id, halt_ex, halt_mem} = 4'hf;
                IDLE: begin
                    if (mem_op || ext_halt) begin
                        {halt_if, halt_id, halt_ex, halt_mem} = 4'hf;
                    end else if (ex_branch_taken) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (load_use) begin
                        halt_if  = 1'b1;
                        halt_id  = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                default:  {halt_if, halt_id, halt_ex, halt_mem} = 4'hf;
            endcase
        end
    end

    // Memory request, timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op && !ext_halt) begin
                        req_q <= 1'b1;
                        we_q  <= mem_memwrite;
                        cnt_q <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem.dmem_ack) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            req_q <= 1'b0;
                            we_q  <= 1'b0;
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            stall_q <= 32'd0;
        else if (halt_if && stall_q != '1)   stall_q <= stall_q + 32'd1;
    end

    assign dmem.dmem_req = req_q;
    assign dmem.dmem_we  = we_q;
    assign busy          = (state_q != IDLE);
    assign mem_error     = err_q;
    assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Testbench for pipeline_controller: per-cycle expectations queued at
// stimulus time, compared on the falling edge.
module tb_pipeline_controller;

    logic        clk;
    logic        rst;
    logic        ext_halt, mem_memwrite, mem_memtoreg, ex_memtoreg, ex_branch_taken;
    logic [4:0]  ex_write_addr, id_rs1, id_rs2;
    logic        id_uses_rs1, id_uses_rs2;
    logic        halt_if, halt_id, halt_ex, halt_mem, flush_id, flush_ex, busy, mem_error;
    logic [31:0] stall_cycles;

    pipeline_controller_if bus ();

    pipeline_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .dmem(bus),
        .ext_halt(ext_halt), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .ex_memtoreg(ex_memtoreg), .ex_write_addr(ex_write_addr),
        .ex_branch_taken(ex_branch_taken), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .halt_if(halt_if), .halt_id(halt_id), .halt_ex(halt_ex), .halt_mem(halt_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .busy(busy), .mem_error(mem_error),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        string       tag;
        logic [9:0]  ctl;   // {halt_if,id,ex,mem, flush_id,ex, busy, req, we, err}
        logic [31:0] stall;
    } sb_entry_t;

    sb_entry_t   sb[$];
    sb_entry_t   mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned exp_sc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expected outputs for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [9:0] ctl);
        sb_entry_t e;
        if (!rst) exp_sc = 0;
        e.tag   = tag;
        e.ctl   = ctl;
        e.stall = exp_sc;
        sb.push_back(e);
        if (rst && ctl[9]) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ext_halt = 0; mem_memwrite = 0; mem_memtoreg = 0; ex_memtoreg = 0;
        ex_branch_taken = 0; ex_write_addr = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; bus.dmem_ack = 0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "_ctl"},
                {halt_if, halt_id, halt_ex, halt_mem, flush_id, flush_ex, busy,
                 bus.dmem_req, bus.dmem_we, mem_error}, mon_e.ctl);
            chk({mon_e.tag, "_stall"}, stall_cycles, mon_e.stall);
        end
    end

    initial begin
        rst = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 10'b1111_00_0_000);
        rst = 1;
        cyc("idle", 10'b0000_00_0_000);

        // store, ack in third wait cycle
        mem_memwrite = 1;
        cyc("st_det", 10'b1111_00_0_000);
        cyc("st_w1",  10'b1111_00_1_110);
        cyc("st_w2",  10'b1111_00_1_110);
        bus.dmem_ack = 1;
        cyc("st_w3",  10'b0000_00_1_110);
        bus.dmem_ack = 0; mem_memwrite = 0;
        cyc("st_done", 10'b0000_00_0_000);

        // ack while no request is outstanding
        bus.dmem_ack = 1;
        cyc("stray_ack", 10'b0000_00_0_000);
        bus.dmem_ack = 0;
        cyc("stray_after", 10'b0000_00_0_000);

        // load-use via rs2, then cleared, then zero register, rs1, unused source
        ex_memtoreg = 1; ex_write_addr = 5; id_rs2 = 5; id_uses_rs2 = 1;
        cyc("lu_rs2", 10'b1100_01_0_000);
        ex_memtoreg = 0;
        cyc("lu_clear", 10'b0000_00_0_000);
        ex_memtoreg = 1; ex_write_addr = 31; id_rs2 = 31;
        cyc("lu_r31", 10'b0000_00_0_000);
        ex_write_addr = 7; id_rs1 = 7; id_uses_rs1 = 1; id_uses_rs2 = 0;
        cyc("lu_rs1", 10'b1100_01_0_000);
        id_uses_rs1 = 0;
        cyc("lu_unused", 10'b0000_00_0_000);

        // branch beats load-use
        id_uses_rs1 = 1; ex_branch_taken = 1;
        cyc("br_over_lu", 10'b0000_11_0_000);
        idle_inputs();

        // taken branch held during a load wait
        mem_memtoreg = 1; ex_branch_taken = 1;
        cyc("brw_det", 10'b1111_00_0_000);
        cyc("brw_w1",  10'b1111_00_1_100);
        bus.dmem_ack = 1;
        cyc("brw_w2",  10'b0000_00_1_100);
        bus.dmem_ack = 0; mem_memtoreg = 0;
        cyc("brw_flush", 10'b0000_11_0_000);
        ex_branch_taken = 0;
        cyc("brw_idle", 10'b0000_00_0_000);

        // asynchronous reset in the second wait cycle
        mem_memwrite = 1;
        cyc("rm_det", 10'b1111_00_0_000);
        cyc("rm_w1",  10'b1111_00_1_110);
        #2;
        chk("rm_req_before", bus.dmem_req, 1);
        rst = 0;
        #1;
        chk("rm_req_async", bus.dmem_req, 0);
        chk("rm_busy", busy, 0);
        chk("rm_stall", stall_cycles, 0);
        chk("rm_halts", {halt_if, halt_id, halt_ex, halt_mem}, 4'hf);
        @(posedge clk);
        #1;
        mem_memwrite = 0;
        cyc("rm_hold", 10'b1111_00_0_000);
        rst = 1;
        cyc("rm_idle", 10'b0000_00_0_000);

        // timeout with MEM_TIMEOUT = 4
        mem_memwrite = 1;
        cyc("to_det", 10'b1111_00_0_000);
        cyc("to_w1",  10'b1111_00_1_110);
        cyc("to_w2",  10'b1111_00_1_110);
        cyc("to_w3",  10'b1111_00_1_110);
        cyc("to_w4",  10'b1111_00_1_110);
        cyc("to_err", 10'b1111_00_1_001);
        bus.dmem_ack = 1;
        cyc("to_err_ack", 10'b1111_00_1_001);
        cyc("to_err_stay", 10'b1111_00_1_001);
        bus.dmem_ack = 0; mem_memwrite = 0;
        rst = 0;
        cyc("to_rst", 10'b1111_00_0_000);
        rst = 1;
        cyc("to_idle", 10'b0000_00_0_000);

        // ext_halt raised during a load wait, load-use pending behind it
        mem_memtoreg = 1;
        cyc("eh_det", 10'b1111_00_0_000);
        ext_halt = 1;
        cyc("eh_w1",  10'b1111_00_1_100);
        bus.dmem_ack = 1;
        cyc("eh_ack", 10'b1111_00_1_100);
        bus.dmem_ack = 0; mem_memtoreg = 0;
        ex_memtoreg = 1; ex_write_addr = 9; id_rs2 = 9; id_uses_rs2 = 1;
        cyc("eh_held", 10'b1111_00_0_000);
        mem_memwrite = 1;
        cyc("eh_no_entry", 10'b1111_00_0_000);
        mem_memwrite = 0; ext_halt = 0;
        cyc("eh_bubble", 10'b1100_01_0_000);
        idle_inputs();
        cyc("eh_idle", 10'b0000_00_0_000);

        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
